// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and the IF_ID register,
// selects the next PC from decode redirects and load-use stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic        PC_IF_ID_Write,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        interrupt,
  input  logic        exception,
  output logic [63:0] IF_ID,
  output logic [31:0] pc
);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } if_id_t;

  logic [31:0] pc_q;
  logic [31:0] pc_inc;
  logic [31:0] next_pc;
  logic [31:0] t_inc;
  logic        redirect;
  logic        trap;
  logic        hold;
  if_id_t      if_id_q;
  if_id_t      if_id_d;

  // bit 31 (supervisor) is sticky; carry out of bit 30 drops
  function automatic logic [31:0] inc4(input logic [31:0] a);
    return {a[31], a[30:0] + 31'd4};
  endfunction

  assign pc_inc    = inc4(pc_q);
  assign inst_addr = pc_q;
  assign pc        = pc_q;
  assign IF_ID     = if_id_q;

  assign trap     = interrupt | exception;
  assign redirect = trap | JR | J | Z;
  assign hold     = ~PC_IF_ID_Write & ~trap;

  always_comb begin
    next_pc = pc_inc;
    priority case (1'b1)
      interrupt: next_pc = ILLOP_PC;
      exception: next_pc = XADR_PC;
      JR:        next_pc = jr_target;
      J:         next_pc = jump_target;
      Z:         next_pc = branch_target;
      default:   next_pc = pc_inc;
    endcase
  end

  assign t_inc = inc4(next_pc);

  // a flushed slot is a nop whose PC+4 names the target
  always_comb begin
    if_id_d.pc4  = pc_inc;
    if_id_d.inst = inst_data;
    if (redirect) begin
      if_id_d.pc4  = t_inc;
      if_id_d.inst = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      if_id_q <= '0;
    end else if (!hold) begin
      pc_q    <= next_pc;
      if_id_q <= if_id_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, wraps,
// redirects, stalls, trap priority and async reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        Z, J, JR, PC_IF_ID_Write;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        interrupt, exception;
  logic [63:0] IF_ID;
  logic [31:0] pc;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst_addr(inst_addr),
    .inst_data(inst_data),
    .Z(Z),
    .J(J),
    .JR(JR),
    .PC_IF_ID_Write(PC_IF_ID_Write),
    .branch_target(branch_target),
    .jump_target(jump_target),
    .jr_target(jr_target),
    .interrupt(interrupt),
    .exception(exception),
    .IF_ID(IF_ID),
    .pc(pc)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Z = 0; J = 0; JR = 0;
    interrupt = 0; exception = 0;
    PC_IF_ID_Write = 1;
  endtask

  initial begin
    rst_n = 0;
    inst_data = 32'h2408_0001;
    branch_target = 0;
    jump_target = 0;
    jr_target = 0;
    clr();
    #12;
    check("rst_addr", inst_addr, 32'h8000_0000);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_ifid", IF_ID, 64'h0);
    @(negedge clk);
    rst_n = 1;

    step();
    check("e1_ifid", IF_ID, 64'h8000_0004_2408_0001);
    check("e1_pc", pc, 32'h8000_0004);
    step();
    step();
    check("e3_pc", pc, 32'h8000_000C);

    J = 1; jump_target = 32'h7FFF_FFFC;
    step();
    check("j_pc", pc, 32'h7FFF_FFFC);
    check("j_ifid", IF_ID, 64'h0000_0000_0000_0000);
    J = 0;
    step();
    check("wrap0_pc", pc, 32'h0000_0000);
    check("wrap0_ifid", IF_ID, 64'h0000_0000_2408_0001);

    J = 1; jump_target = 32'hFFFF_FFFC;
    step();
    check("j2_ifid", IF_ID, 64'h8000_0000_0000_0000);
    J = 0;
    step();
    check("wrap1_pc", pc, 32'h8000_0000);

    J = 1; jump_target = 32'h0000_0010;
    step();
    J = 0; Z = 1; branch_target = 32'h0000_0040;
    step();
    check("br_pc", pc, 32'h0000_0040);
    check("br_ifid", IF_ID, 64'h0000_0044_0000_0000);
    Z = 0; inst_data = 32'h1111_1111;
    step();
    check("br2_ifid", IF_ID, 64'h0000_0044_1111_1111);
    check("br2_pc", pc, 32'h0000_0044);

    PC_IF_ID_Write = 0; J = 1; jump_target = 32'h0000_0100;
    step();
    check("st1_pc", pc, 32'h0000_0044);
    check("st1_ifid", IF_ID, 64'h0000_0044_1111_1111);
    step();
    check("st2_pc", pc, 32'h0000_0044);
    check("st2_ifid", IF_ID, 64'h0000_0044_1111_1111);
    PC_IF_ID_Write = 1;
    step();
    check("st3_pc", pc, 32'h0000_0100);
    check("st3_ifid", IF_ID, 64'h0000_0104_0000_0000);
    clr();

    interrupt = 1; PC_IF_ID_Write = 0;
    JR = 1; jr_target = 32'h1234_5678;
    step();
    check("irq_pc", pc, 32'h8000_0004);
    check("irq_ifid", IF_ID, 64'h8000_0008_0000_0000);
    clr();

    interrupt = 1; exception = 1;
    step();
    check("irqx_pc", pc, 32'h8000_0004);
    clr();

    J = 1; jump_target = 32'h0000_0020;
    step();
    J = 0; exception = 1;
    step();
    check("exc_pc", pc, 32'h8000_0008);
    check("exc_ifid", IF_ID, 64'h8000_000C_0000_0000);
    clr();

    JR = 1; jr_target = 32'h0000_0200;
    J = 1; jump_target = 32'h0000_0300;
    Z = 1; branch_target = 32'h0000_0400;
    step();
    check("jr_pc", pc, 32'h0000_0200);
    check("jr_ifid", IF_ID, 64'h0000_0204_0000_0000);
    clr();
    J = 1; jump_target = 32'h0000_0300;
    Z = 1; branch_target = 32'h0000_0400;
    step();
    check("jz_pc", pc, 32'h0000_0300);
    clr();

    inst_data = 32'h2222_2222;
    step();
    check("pre_rst_ifid", IF_ID, 64'h0000_0304_2222_2222);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check("arst_pc", pc, 32'h8000_0000);
    check("arst_ifid", IF_ID, 64'h0);
    step();
    @(negedge clk);
    rst_n = 1;
    step();
    check("post_rst_pc", pc, 32'h8000_0004);
    check("post_rst_ifid", IF_ID, 64'h8000_0004_2222_2222);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
